row_rasterizer: RTL and testbench
=================================

Name: row_rasterizer

Overview:
- Fills the 24-bit row buffer that the VGA streamer reads, one row per `next_row` request.
- Sits between the entity double memory (read side) and the row double memory (write side), all in the 50 MHz `clock` domain.
- For the current row it clears the row to the background colour, then scans the entity list and paints every square entity that intersects the row.
- Entity word, 21 bits: [20:12] x, [11:3] y, [2:0] colour index.

Parameters:
- WIDTH, 320: visible pixels per row; addresses 0..WIDTH-1 are written, max 512.
- HEIGHT, 240: rows per screen; the row counter saturates at HEIGHT-1.
- SIZE, 16: side length of an entity square in pixels.
- BG_COLOUR, 24'h000000: background RGB.

Ports:
- clock  in  1  system clock
- reset_reset_n  in  1  asynchronous active-low reset
- next_row  in  1  one-cycle pulse; render the current row
- next_screen  in  1  one-cycle pulse; restart at row 0
- entities_number  in  8  count of valid entities, sampled at row start
- address_read_ent  out  8  entity memory read address
- data_read_ent  in  21  entity word, valid 1 cycle after address
- address_write_row  out  9  row buffer write address
- data_write_row  out  24  row buffer write data (RGB)
- wren  out  1  row buffer write enable
- busy  out  1  high from accepted next_row until the row is complete
- overrun  out  1  sticky; set when next_row arrives while busy

Behaviour:
- Reset (async, active-low): all outputs 0, state IDLE, row counter 0, overrun cleared.
- IDLE:
  - next_row: latch entities_number into n_ent, go to CLEAR, busy=1.
  - next_screen: row counter := 0.
- CLEAR:
  - One write per cycle, addresses 0..WIDTH-1, data BG_COLOUR, wren=1.
  - After WIDTH-1: if n_ent==0 go to FINISH, else i:=0 and go to FETCH.
- FETCH: drive address_read_ent=i, wren=0, go to WAIT.
- WAIT: one bubble for memory latency; capture data_read_ent at the end of the cycle, go to TEST.
- TEST:
  - Hit when y <= row < y+SIZE, compared in 10-bit arithmetic so there is no wrap.
  - Hit: px:=x, go to DRAW.
  - Miss: i++; go to FINISH if i==n_ent, else FETCH.
- DRAW:
  - Write palette(colour) at px, px++.
  - Stop after SIZE writes or when px==WIDTH-1 has been written (right-edge clip).
  - x>=WIDTH produces zero writes.
  - Then i++ and go to FETCH or FINISH as in TEST.
- FINISH: row counter++ (saturating at HEIGHT-1), busy=0, go to IDLE.
- Overlap: later entities overwrite earlier ones (painter's order by index).
- next_screen while busy: abort immediately to IDLE, wren=0 next cycle, row counter := 0, busy=0.
- next_row while busy: ignored and overrun:=1. overrun clears only on reset or next_screen.
- next_row and next_screen in the same cycle: next_screen wins, and the row starts at row 0 from IDLE on the next pulse.
- Palette: 3-bit index to 24-bit RGB, registered together with the address so wren, address and data stay aligned.
- Latency: CLEAR takes WIDTH cycles. Each entity costs 3 cycles plus SIZE cycles if hit. Worst case at 320/16/256 is ≈320+256·19=5184 cycles. The display-side budget is the caller's concern; overrun flags violations.

Optional Feature:
- Macro: ROW_RASTERIZER_OUTLINE_EN.
- Defined: the pixels of each square with local row 0 or SIZE-1, or local column 0 or SIZE-1, are written as 24'h000000; interior pixels use the palette colour.
- Undefined: the whole square is the palette colour.
- Write count and timing are identical in both builds.

Decomposition:
- Package raster_pkg holds:
  - entity field offsets/widths: X_MSB=20, X_LSB=12, Y_MSB=11, Y_LSB=3, C_MSB=2
  - the state enum: IDLE, CLEAR, FETCH, WAIT, TEST, DRAW, FINISH
  - the 8-entry palette constant
- One sub-module, colour_palette: registered 3-to-24 lookup shared with entities_drawer debugging.

Test Plan:
- Reset, then next_row with entities_number=0 → 320 writes of 24'h000000 at addresses 0..319; busy falls; row counter=1.
- Entity {x=10, y=0, c=1} with next_row at row 0 → CLEAR, then 16 writes of palette[1] at addresses 10..25; busy low after 320+3+16 cycles ±1.
- Entity x=310 → exactly 10 writes at 310..319; no write to 320+.
- Entity y=5 → rows 0–4 show no entity writes, rows 5–20 show 16 entity writes each, row 21 shows none.
- Two entities at the same x, indices 0 (c=2) and 1 (c=3) → last writes to the shared addresses carry palette[3].
- next_row pulsed mid-DRAW → overrun=1, rendering unaffected. next_screen mid-row → wren low next cycle, busy=0, next row renders row 0, overrun cleared.

Source files
------------

// File: rtl/raster_pkg.sv
// raster_pkg: shared definitions for the row rasterizer.
//   - entity word field positions (21-bit word: [20:12] x, [11:3] y, [2:0] colour)
//   - rasterizer FSM state encoding
//   - 8-entry RGB palette and its lookup helper
package raster_pkg;

    localparam int ENT_W = 21;
    localparam int X_MSB = 20;
    localparam int X_LSB = 12;
    localparam int Y_MSB = 11;
    localparam int Y_LSB = 3;
    localparam int C_MSB = 2;
    localparam int C_LSB = 0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        FETCH  = 3'd2,
        WAIT   = 3'd3,
        TEST   = 3'd4,
        DRAW   = 3'd5,
        FINISH = 3'd6
    } raster_state_t;

    localparam logic [23:0] PALETTE [0:7] = '{
        24'h808080, 24'hFF0000, 24'h00FF00, 24'h0000FF,
        24'hFFFF00, 24'hFF00FF, 24'h00FFFF, 24'hFFFFFF
    };

    function automatic logic [23:0] palette_rgb(input logic [2:0] idx);
        return PALETTE[idx];
    endfunction

endpackage

// File: rtl/colour_palette.sv
// colour_palette: registered 3-bit index to 24-bit RGB lookup.
// Ports:
//   clock      system clock
//   rst_n      asynchronous active-low reset (output cleared to 0)
//   srst       synchronous clear (output cleared to 0)
//   clr_sel    select the background colour instead of the palette
//   blk_sel    select black (square outline) instead of the palette
//   colour_idx palette index
//   rgb        registered colour, one cycle after the inputs
module colour_palette
    import raster_pkg::*;
#(
    parameter logic [23:0] BG_COLOUR = 24'h000000
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        srst,
    input  logic        clr_sel,
    input  logic        blk_sel,
    input  logic [2:0]  colour_idx,
    output logic [23:0] rgb
);

    logic [23:0] rgb_r;

    // Colour register; background has priority over outline black.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            rgb_r <= 24'h000000;
        end else if (srst) begin
            rgb_r <= 24'h000000;
        end else if (clr_sel) begin
            rgb_r <= BG_COLOUR;
        end else if (blk_sel) begin
            rgb_r <= 24'h000000;
        end else begin
            rgb_r <= palette_rgb(colour_idx);
        end
    end

    assign rgb = rgb_r;

endmodule

// File: rtl/row_rasterizer.sv
// row_rasterizer: renders one display row into the row buffer per next_row
// pulse. The row is first cleared to BG_COLOUR, then every entity in the
// entity memory (index 0..n-1, painter's order) whose SIZE x SIZE square
// covers the current row is painted, clipped at the right edge.
// Optional build macro ROW_RASTERIZER_OUTLINE_EN: square border pixels are
// written black; write count and timing are unchanged.
// Ports:
//   clock, reset_reset_n        clock, async active-low reset
//   next_row / next_screen      render current row / restart at row 0 (abort)
//   entities_number             entity count, latched when a row starts
//   address_read_ent, data_read_ent   entity memory (1-cycle read latency)
//   address_write_row, data_write_row, wren   row buffer write port
//   busy                        row in progress
//   overrun                     sticky: next_row seen while busy
module row_rasterizer
    import raster_pkg::*;
#(
    parameter int unsigned WIDTH     = 320,
    parameter int unsigned HEIGHT    = 240,
    parameter int unsigned SIZE      = 16,
    parameter logic [23:0] BG_COLOUR = 24'h000000
) (
    input  logic        clock,
    input  logic        reset_reset_n,
    input  logic        next_row,
    input  logic        next_screen,
    input  logic [7:0]  entities_number,
    output logic [7:0]  address_read_ent,
    input  logic [20:0] data_read_ent,
    output logic [8:0]  address_write_row,
    output logic [23:0] data_write_row,
    output logic        wren,
    output logic        busy,
    output logic        overrun
);

    localparam int unsigned CNT_W = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [8:0]  LAST_PX  = 9'(WIDTH - 1);
    localparam logic [9:0]  WIDTH_10 = 10'(WIDTH);
    localparam logic [9:0]  SIZE_10  = 10'(SIZE);
    localparam logic [8:0]  LAST_ROW = 9'(HEIGHT - 1);
    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(SIZE - 1);
`ifdef ROW_RASTERIZER_OUTLINE_EN
    localparam bit OUTLINE_EN = 1'b1;
`else
    localparam bit OUTLINE_EN = 1'b0;
`endif

    raster_state_t    state_r, state_next_s;
    logic [7:0]       n_ent_r;
    logic [7:0]       ent_idx_r;
    logic [8:0]       clr_addr_r;
    logic [8:0]       row_r;
    logic [8:0]       ent_x_r, ent_y_r;
    logic [2:0]       ent_c_r;
    logic [8:0]       px_r;
    logic [CNT_W-1:0] col_r, lrow_r;
    logic             overrun_r, busy_r, wren_r;
    logic [8:0]       waddr_r;

    logic             hit_s, x_vis_s, last_ent_s, draw_done_s, edge_s;
    logic             we_s, clr_sel_s, blk_sel_s;
    logic [8:0]       waddr_s;

    // 10-bit compares so y+SIZE never wraps.
    assign hit_s       = ({1'b0, ent_y_r} <= {1'b0, row_r}) &&
                         ({1'b0, row_r} < ({1'b0, ent_y_r} + SIZE_10));
    assign x_vis_s     = ({1'b0, ent_x_r} < WIDTH_10);
    assign last_ent_s  = (({1'b0, ent_idx_r} + 9'd1) == {1'b0, n_ent_r});
    assign draw_done_s = (col_r == LAST_COL) || (px_r == LAST_PX);
    assign edge_s      = (lrow_r == {CNT_W{1'b0}}) || (lrow_r == LAST_COL) ||
                         (col_r == {CNT_W{1'b0}}) || (col_r == LAST_COL);

    // Next-state and write-request decode; next_screen aborts from any state.
    always_comb begin
        state_next_s = state_r;
        we_s         = 1'b0;
        waddr_s      = 9'd0;
        clr_sel_s    = 1'b0;
        blk_sel_s    = 1'b0;
        if (next_screen) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (next_row) begin
                        state_next_s = CLEAR;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                CLEAR: begin
                    we_s      = 1'b1;
                    waddr_s   = clr_addr_r;
                    clr_sel_s = 1'b1;
                    if (clr_addr_r == LAST_PX) begin
                        if (n_ent_r == 8'd0) begin
                            state_next_s = FINISH;
                        end else begin
                            state_next_s = FETCH;
                        end
                    end else begin
                        state_next_s = CLEAR;
                    end
                end
                FETCH: state_next_s = WAIT;
                WAIT:  state_next_s = TEST;
                TEST: begin
                    // Off-screen hits skip DRAW entirely: zero writes.
                    if (hit_s && x_vis_s) begin
                        state_next_s = DRAW;
                    end else if (last_ent_s) begin
                        state_next_s = FINISH;
                    end else begin
                        state_next_s = FETCH;
                    end
                end
                DRAW: begin
                    we_s      = 1'b1;
                    waddr_s   = px_r;
                    blk_sel_s = OUTLINE_EN && edge_s;
                    if (draw_done_s) begin
                        if (last_ent_s) begin
                            state_next_s = FINISH;
                        end else begin
                            state_next_s = FETCH;
                        end
                    end else begin
                        state_next_s = DRAW;
                    end
                end
                FINISH:  state_next_s = IDLE;
                default: state_next_s = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Row datapath: counters, entity capture, row counter and overrun flag.
    always_ff @(posedge clock or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            n_ent_r    <= 8'd0;
            ent_idx_r  <= 8'd0;
            clr_addr_r <= 9'd0;
            row_r      <= 9'd0;
            ent_x_r    <= 9'd0;
            ent_y_r    <= 9'd0;
            ent_c_r    <= 3'd0;
            px_r       <= 9'd0;
            col_r      <= {CNT_W{1'b0}};
            lrow_r     <= {CNT_W{1'b0}};
            overrun_r  <= 1'b0;
        end else if (next_screen) begin
            row_r     <= 9'd0;
            overrun_r <= 1'b0;
        end else begin
            if (next_row && (state_r != IDLE)) begin
                overrun_r <= 1'b1;
            end
            case (state_r)
                IDLE: begin
                    if (next_row) begin
                        n_ent_r    <= entities_number;
                        ent_idx_r  <= 8'd0;
                        clr_addr_r <= 9'd0;
                    end
                end
                CLEAR: clr_addr_r <= clr_addr_r + 9'd1;
                WAIT: begin
                    ent_x_r <= data_read_ent[X_MSB:X_LSB];
                    ent_y_r <= data_read_ent[Y_MSB:Y_LSB];
                    ent_c_r <= data_read_ent[C_MSB:C_LSB];
                end
                TEST: begin
                    px_r   <= ent_x_r;
                    col_r  <= {CNT_W{1'b0}};
                    // Only meaningful on a hit, where row - y < SIZE.
                    lrow_r <= CNT_W'(row_r - ent_y_r);
                    if (!(hit_s && x_vis_s)) begin
                        ent_idx_r <= ent_idx_r + 8'd1;
                    end
                end
                DRAW: begin
                    px_r  <= px_r + 9'd1;
                    col_r <= col_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (draw_done_s) begin
                        ent_idx_r <= ent_idx_r + 8'd1;
                    end
                end
                FINISH: begin
                    if (row_r != LAST_ROW) begin
                        row_r <= row_r + 9'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output stage: write strobe and address registered alongside palette data.
    always_ff @(posedge clock or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wren_r  <= 1'b0;
            waddr_r <= 9'd0;
            busy_r  <= 1'b0;
        end else begin
            wren_r  <= we_s;
            waddr_r <= waddr_s;
            busy_r  <= (state_next_s != IDLE);
        end
    end

    colour_palette #(
        .BG_COLOUR (BG_COLOUR)
    ) u_palette (
        .clock      (clock),
        .rst_n      (reset_reset_n),
        .srst       (next_screen),
        .clr_sel    (clr_sel_s),
        .blk_sel    (blk_sel_s),
        .colour_idx (ent_c_r),
        .rgb        (data_write_row)
    );

    assign address_read_ent  = ent_idx_r;
    assign address_write_row = waddr_r;
    assign wren              = wren_r;
    assign busy              = busy_r;
    assign overrun           = overrun_r;

endmodule

// File: tb/tb_row_rasterizer.sv
// tb_row_rasterizer: randomized self-checking bench for row_rasterizer.
// A pixel-level reference model paints each expected row from the entity
// list and the bench compares the captured row buffer, write count, busy
// duration and status flags.
module tb_row_rasterizer;

    localparam int WIDTH = 320;
    localparam int SIZE  = 16;
    localparam int HEIGHT = 240;
    localparam logic [23:0] BG = 24'h000000;
    localparam int LIMIT = 20000;
`ifdef ROW_RASTERIZER_OUTLINE_EN
    localparam bit OUTLINE = 1'b1;
`else
    localparam bit OUTLINE = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_reset_n = 1'b0;
    logic        next_row = 1'b0;
    logic        next_screen = 1'b0;
    logic [7:0]  entities_number = 8'd0;
    logic [7:0]  address_read_ent;
    logic [20:0] data_read_ent;
    logic [8:0]  address_write_row;
    logic [23:0] data_write_row;
    logic        wren, busy, overrun;

    logic [20:0] ent_mem [0:255];
    logic [23:0] pal [0:7];
    int err_cnt = 0;
    int chk_cnt = 0;
    int exp_row = 0;
    bit exp_overrun = 1'b0;

    row_rasterizer dut (
        .clock             (clock),
        .reset_reset_n     (reset_reset_n),
        .next_row          (next_row),
        .next_screen       (next_screen),
        .entities_number   (entities_number),
        .address_read_ent  (address_read_ent),
        .data_read_ent     (data_read_ent),
        .address_write_row (address_write_row),
        .data_write_row    (data_write_row),
        .wren              (wren),
        .busy              (busy),
        .overrun           (overrun)
    );

    always #10 clock = ~clock;

    // Synchronous entity memory, one cycle of read latency.
    always @(posedge clock) data_read_ent <= ent_mem[address_read_ent];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [20:0] ent(input int x, input int y, input int c);
        logic [8:0] xv, yv;
        logic [2:0] cv;
        xv = 9'(x);
        yv = 9'(y);
        cv = 3'(c);
        return {xv, yv, cv};
    endfunction

    task automatic pulse_screen();
        @(negedge clock);
        next_screen = 1'b1;
        @(negedge clock);
        next_screen = 1'b0;
        exp_row = 0;
        exp_overrun = 1'b0;
    endtask

    // Render one row; nr_at / ns_at pulse next_row / next_screen at that busy cycle (-1 = never).
    task automatic run_row(input int n, input int nr_at, input int ns_at);
        logic [23:0] got [0:WIDTH-1];
        logic [23:0] expv [0:WIDTH-1];
        logic [20:0] w;
        int writes, oob, cyc, exp_writes, exp_cyc, x, y, c, p;
        bit aborted;
        writes = 0; oob = 0; cyc = 0; aborted = 1'b0;
        // Reference: clear, then paint entities in index order.
        for (int i = 0; i < WIDTH; i++) begin
            expv[i] = BG;
            got[i]  = 24'h5A5A5A;
        end
        exp_writes = WIDTH;
        exp_cyc    = WIDTH + 1;
        for (int k = 0; k < n; k++) begin
            w = ent_mem[k];
            x = int'(w[20:12]);
            y = int'(w[11:3]);
            c = int'(w[2:0]);
            exp_cyc += 3;
            if (exp_row >= y && exp_row < y + SIZE) begin
                for (int col = 0; col < SIZE; col++) begin
                    p = x + col;
                    if (p < WIDTH) begin
                        if (OUTLINE && (exp_row == y || exp_row == y + SIZE - 1 ||
                                        col == 0 || col == SIZE - 1))
                            expv[p] = 24'h000000;
                        else
                            expv[p] = pal[c];
                        exp_writes++;
                        exp_cyc++;
                    end
                end
            end
        end
        @(negedge clock);
        entities_number = 8'(n);
        next_row = 1'b1;
        @(negedge clock);
        next_row = 1'b0;
        entities_number = 8'($urandom);
        while (busy === 1'b1 && cyc < LIMIT) begin
            if (wren === 1'b1) begin
                writes++;
                if (address_write_row < 9'(WIDTH)) got[address_write_row] = data_write_row;
                else oob++;
            end
            next_row    = (cyc == nr_at);
            next_screen = (cyc == ns_at);
            if (cyc == ns_at) aborted = 1'b1;
            if (cyc == nr_at) exp_overrun = 1'b1;
            cyc++;
            @(negedge clock);
        end
        next_row = 1'b0;
        next_screen = 1'b0;
        check_eq("busy_bounded", (cyc < LIMIT) ? 32'd1 : 32'd0, 32'd1);
        check_eq("wren_after_row", {31'd0, wren}, 32'd0);
        if (aborted) begin
            exp_row = 0;
            exp_overrun = 1'b0;
            check_eq("abort_cycle", cyc, ns_at + 1);
            check_eq("abort_busy", {31'd0, busy}, 32'd0);
            check_eq("abort_overrun", {31'd0, overrun}, 32'd0);
        end else begin
            check_eq("busy_cycles", cyc, exp_cyc);
            check_eq("write_count", writes, exp_writes);
            check_eq("oob_writes", oob, 0);
            check_eq("overrun", {31'd0, overrun}, {31'd0, exp_overrun});
            for (int i = 0; i < WIDTH; i++)
                check_eq($sformatf("row%0d_pix%0d", exp_row, i), got[i], expv[i]);
            if (exp_row < HEIGHT - 1) exp_row++;
        end
    endtask

    initial begin
        pal[0] = 24'h808080; pal[1] = 24'hFF0000; pal[2] = 24'h00FF00; pal[3] = 24'h0000FF;
        pal[4] = 24'hFFFF00; pal[5] = 24'hFF00FF; pal[6] = 24'h00FFFF; pal[7] = 24'hFFFFFF;
        for (int i = 0; i < 256; i++) ent_mem[i] = 21'd0;

        // Reset values.
        repeat (3) @(negedge clock);
        check_eq("rst_wren", {31'd0, wren}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_overrun", {31'd0, overrun}, 32'd0);
        check_eq("rst_waddr", {23'd0, address_write_row}, 32'd0);
        check_eq("rst_wdata", {8'd0, data_write_row}, 32'd0);
        check_eq("rst_raddr", {24'd0, address_read_ent}, 32'd0);
        reset_reset_n = 1'b1;

        // Empty list: clear only.
        run_row(0, -1, -1);

        // Single entity at row 0.
        ent_mem[0] = ent(10, 0, 1);
        pulse_screen();
        run_row(1, -1, -1);

        // Right-edge clip (row 1).
        ent_mem[0] = ent(310, 0, 6);
        run_row(1, -1, -1);

        // Vertical extent rows 0..21 for y=5.
        pulse_screen();
        ent_mem[0] = ent(100, 5, 4);
        for (int r = 0; r < 22; r++) run_row(1, -1, -1);

        // Painter's order at shared addresses; also an off-screen x.
        pulse_screen();
        ent_mem[0] = ent(50, 0, 2);
        ent_mem[1] = ent(50, 0, 3);
        ent_mem[2] = ent(330, 0, 7);
        run_row(3, -1, -1);

        // next_row mid-DRAW: overrun set, row still correct, flag sticky.
        pulse_screen();
        ent_mem[0] = ent(20, 0, 5);
        run_row(1, 330, -1);
        run_row(1, -1, -1);

        // next_screen mid-CLEAR and mid-DRAW, each followed by row 0.
        run_row(1, -1, 200);
        run_row(1, -1, -1);
        run_row(1, 200, -1);
        run_row(1, -1, 330);
        run_row(1, -1, -1);

        // next_row and next_screen together in IDLE: no row starts.
        @(negedge clock);
        next_row = 1'b1;
        next_screen = 1'b1;
        @(negedge clock);
        next_row = 1'b0;
        next_screen = 1'b0;
        exp_row = 0;
        exp_overrun = 1'b0;
        check_eq("both_busy", {31'd0, busy}, 32'd0);
        @(negedge clock);
        check_eq("both_wren", {31'd0, wren}, 32'd0);
        run_row(1, -1, -1);

        // Full 255-entity list.
        pulse_screen();
        for (int i = 0; i < 256; i++)
            ent_mem[i] = ent($urandom_range(0, 330), $urandom_range(0, 3), $urandom_range(0, 7));
        run_row(255, -1, -1);

        // Randomized rows with occasional screen restarts.
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < 12; i++)
                ent_mem[i] = ent($urandom_range(0, 340), $urandom_range(0, 30), $urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) pulse_screen();
            run_row($urandom_range(0, 12), -1, -1);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
